// File: rtl/qspi_mem_ctrl_pkg.sv
// Shared definitions for the QSPI memory controller: opcodes, target encoding,
// sequencer states and fixed transaction lengths.
package qspi_mem_ctrl_pkg;

  localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
  localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;

  localparam logic TGT_FLASH = 1'b0;
  localparam logic TGT_RAM_A = 1'b1;

  // SCK cycles per phase of a transaction (dummy length is per-target parameter)
  localparam int CMD_SCK  = 8;
  localparam int ADDR_SCK = 6;
  localparam int DATA_SCK = 2;

  // SCK cycle counter width; bounds the largest supported dummy count
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_DONE
  } qspi_state_e;

endpackage

// File: rtl/qspi_mem_ctrl_shift_reg.sv
// 32-bit serialiser/deserialiser. Shifts left by 1 (single-IO command) or
// 4 (quad address/data) bits per SCK; quad shifts pull in a nibble at the LSB.
module qspi_shift_reg (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        shift_i,
  input  logic        quad_i,
  input  logic [3:0]  nib_i,
  output logic [3:0]  out_nib_o,
  output logic [3:0]  in_nib_o
);

  logic [31:0] sr_q;

  // Load has priority over shift; single-IO shifts fill with zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        sr_q <= '0;
    else if (load_i)  sr_q <= load_val_i;
    else if (shift_i) sr_q <= quad_i ? {sr_q[27:0], nib_i} : {sr_q[30:0], 1'b0};
  end

  assign out_nib_o = sr_q[31:28];
  assign in_nib_o  = sr_q[3:0];

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QSPI master: turns single-byte CPU requests into command/address/dummy/data
// transactions to the flash or RAM A. SCK runs at clock/2; ph0 drives, ph1
// raises SCK, and input data is captured on the edge that ends ph1.
module qspi_mem_ctrl
  import qspi_mem_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int FLASH_DUMMY    = 6,
  parameter int RAM_DUMMY      = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_target,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  input  logic [3:0]                spi_data_in,
  output logic [3:0]                spi_data_out,
  output logic [3:0]                spi_data_oe,
  output logic                      spi_clk_out,
  output logic                      spi_flash_select,
  output logic                      spi_ram_a_select
);

  qspi_state_e               state_q;
  logic                      phase_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      write_q;
  logic                      target_q;
  logic [DATA_BUS_WIDTH-1:0] wdata_q;
  logic                      req_ready_q, resp_valid_q, resp_err_q;
  logic [DATA_BUS_WIDTH-1:0] resp_rdata_q;
  logic [3:0]                sio_q, oe_q;
  logic                      sck_q, flash_cs_n_q, ram_cs_n_q;

  logic                      accept;
  logic [7:0]                cmd_op;
  logic [CNT_W-1:0]          dmy_m1;
  logic                      dmy_zero;
  logic                      last_sck;

  logic                      sr_load, sr_shift, sr_quad;
  logic [31:0]               sr_load_val;
  logic [3:0]                sr_nib, sr_out_nib, sr_in_nib;

  assign accept   = req_valid && req_ready_q;
  assign cmd_op   = req_write ? QSPI_CMD_WRITE : QSPI_CMD_READ;
  assign last_sck = phase_q && (cnt_q == '0);

  // Dummy length follows the captured target
  always_comb begin
    dmy_m1   = (target_q == TGT_RAM_A) ? CNT_W'(RAM_DUMMY - 1) : CNT_W'(FLASH_DUMMY - 1);
    dmy_zero = (target_q == TGT_RAM_A) ? (RAM_DUMMY == 0) : (FLASH_DUMMY == 0);
  end

  // Shift register control: outgoing bits shift on ph1 entry so the next
  // ph0 entry can register them; read nibbles shift in on the edge ending ph1
  always_comb begin
    sr_load     = 1'b0;
    sr_load_val = '0;
    sr_shift    = 1'b0;
    sr_quad     = 1'b0;
    sr_nib      = '0;
    unique case (state_q)
      ST_IDLE: begin
        sr_load     = accept;
        sr_load_val = {cmd_op, 24'(req_addr)};
      end
      ST_CMD:   sr_shift = !phase_q;
      ST_ADDR: begin
        sr_quad = 1'b1;
        if (last_sck && write_q) begin
          sr_load     = 1'b1;
          sr_load_val = {wdata_q, 24'h0};
        end else begin
          sr_shift = !phase_q;
        end
      end
      ST_WDATA: begin
        sr_quad  = 1'b1;
        sr_shift = !phase_q;
      end
      ST_RDATA: begin
        sr_quad  = 1'b1;
        sr_shift = phase_q;
        sr_nib   = spi_data_in;
      end
      default: ;
    endcase
  end

  qspi_shift_reg u_sr (
    .clock      (clock),
    .reset      (reset),
    .load_i     (sr_load),
    .load_val_i (sr_load_val),
    .shift_i    (sr_shift),
    .quad_i     (sr_quad),
    .nib_i      (sr_nib),
    .out_nib_o  (sr_out_nib),
    .in_nib_o   (sr_in_nib)
  );

  // Sequencer: accepts requests, walks the transaction and drives all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      target_q     <= TGT_FLASH;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      sio_q        <= '0;
      oe_q         <= '0;
      sck_q        <= 1'b0;
      flash_cs_n_q <= 1'b1;
      ram_cs_n_q   <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            write_q     <= req_write;
            target_q    <= req_target;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            phase_q     <= 1'b0;
            if (req_write && (req_target == TGT_FLASH)) begin
              // Flash is read-only: reject without touching the bus
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q      <= ST_CMD;
              cnt_q        <= CNT_W'(CMD_SCK - 1);
              resp_err_q   <= 1'b0;
              flash_cs_n_q <= (req_target != TGT_FLASH);
              ram_cs_n_q   <= (req_target != TGT_RAM_A);
              sio_q        <= {3'b000, cmd_op[7]};
              oe_q         <= 4'b0001;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            sck_q   <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            sck_q   <= 1'b0;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
              unique case (state_q)
                ST_CMD:            sio_q <= {3'b000, sr_out_nib[3]};
                ST_ADDR, ST_WDATA: sio_q <= sr_out_nib;
                default:           sio_q <= '0;
              endcase
            end else begin
              case (state_q)
                ST_CMD: begin
                  state_q <= ST_ADDR;
                  cnt_q   <= CNT_W'(ADDR_SCK - 1);
                  sio_q   <= sr_out_nib;
                  oe_q    <= 4'b1111;
                end
                ST_ADDR: begin
                  if (write_q) begin
                    state_q <= ST_WDATA;
                    cnt_q   <= CNT_W'(DATA_SCK - 1);
                    sio_q   <= wdata_q[7:4];
                    oe_q    <= 4'b1111;
                  end else begin
                    sio_q <= '0;
                    oe_q  <= '0;
                    if (dmy_zero) begin
                      state_q <= ST_RDATA;
                      cnt_q   <= CNT_W'(DATA_SCK - 1);
                    end else begin
                      state_q <= ST_DUMMY;
                      cnt_q   <= dmy_m1;
                    end
                  end
                end
                ST_DUMMY: begin
                  state_q <= ST_RDATA;
                  cnt_q   <= CNT_W'(DATA_SCK - 1);
                end
                default: begin
                  // End of data phase: release the bus and respond
                  state_q      <= ST_DONE;
                  resp_valid_q <= 1'b1;
                  flash_cs_n_q <= 1'b1;
                  ram_cs_n_q   <= 1'b1;
                  sio_q        <= '0;
                  oe_q         <= '0;
                  if (state_q == ST_RDATA) resp_rdata_q <= {sr_in_nib, spi_data_in};
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_err         = resp_err_q;
  assign spi_data_out     = sio_q;
  assign spi_data_oe      = oe_q;
  assign spi_clk_out      = sck_q;
  assign spi_flash_select = flash_cs_n_q;
  assign spi_ram_a_select = ram_cs_n_q;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Bench for qspi_mem_ctrl: a QSPI device model decodes bus traffic and
// serves flash/RAM data; a request-level reference predicts latency and data.
module tb_qspi_mem_ctrl;

  localparam int FD = 6;
  localparam int RD = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_target;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [7:0]  resp_rdata;
  logic [3:0]  spi_data_in, spi_data_out, spi_data_oe;
  logic        spi_clk_out, spi_flash_select, spi_ram_a_select;

  int n_cmp = 0;
  int n_bad = 0;

  qspi_mem_ctrl #(
    .ADDRESS_WIDTH(16), .DATA_BUS_WIDTH(8), .FLASH_DUMMY(FD), .RAM_DUMMY(RD)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_target(req_target), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
    .spi_clk_out(spi_clk_out), .spi_flash_select(spi_flash_select),
    .spi_ram_a_select(spi_ram_a_select)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] flash_init(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction

  function automatic logic [7:0] ram_init(input logic [15:0] a);
    return a[7:0] + 8'h33;
  endfunction

  // ---------------- device model / bus monitor ----------------
  int          sck_rises = 0, txn_cnt = 0, oe_bad = 0, cs_both = 0, sck_idle = 0, tgt_bad = 0;
  int          min_gap = 1000;
  logic [7:0]  last_cmd, last_wd;
  logic [23:0] last_addr;
  logic        last_tgt;
  int          last_n;

  initial begin
    int          n, hi_run, dmy;
    bit          seen;
    logic        prev_sck, m_tgt;
    logic [7:0]  m_cmd, m_wd, byt;
    logic [23:0] m_addr;
    logic [3:0]  exp_oe;
    logic [7:0]  dev_ram [logic [15:0]];
    n = 0; hi_run = 0; seen = 0; prev_sck = 0; m_tgt = 0;
    m_cmd = '0; m_wd = '0; m_addr = '0;
    spi_data_in = 4'h0;
    forever begin
      @(negedge clock);
      if (!spi_flash_select && !spi_ram_a_select) cs_both++;
      if (spi_flash_select && spi_ram_a_select) begin
        if (spi_clk_out) sck_idle++;
        if (n > 0) begin
          last_cmd = m_cmd; last_addr = m_addr; last_wd = m_wd; last_tgt = m_tgt; last_n = n;
          txn_cnt++;
        end
        n = 0;
        hi_run++;
      end else begin
        if (hi_run > 0) begin
          if (seen && hi_run < min_gap) min_gap = hi_run;
          seen = 1; hi_run = 0;
        end
        if (spi_clk_out && !prev_sck) begin
          sck_rises++;
          n++;
          if (n > 1 && m_tgt != !spi_ram_a_select) tgt_bad++;
          m_tgt = !spi_ram_a_select;
          dmy = m_tgt ? RD : FD;
          if (n <= 8) begin
            m_cmd = {m_cmd[6:0], spi_data_out[0]};
            exp_oe = 4'b0001;
          end else if (n <= 14) begin
            m_addr = {m_addr[19:0], spi_data_out};
            exp_oe = 4'b1111;
          end else if (m_cmd == 8'h38) begin
            m_wd = {m_wd[3:0], spi_data_out};
            exp_oe = 4'b1111;
            if (n == 16) dev_ram[m_addr[15:0]] = m_wd;
          end else begin
            exp_oe = 4'b0000;
            if (n <= 14 + dmy) begin
              if (spi_data_out !== 4'h0) oe_bad++;
            end else begin
              if (m_tgt) byt = dev_ram.exists(m_addr[15:0]) ? dev_ram[m_addr[15:0]] : ram_init(m_addr[15:0]);
              else       byt = flash_init(m_addr[15:0]);
              spi_data_in = (n == 15 + dmy) ? byt[7:4] : byt[3:0];
            end
          end
          if (spi_data_oe !== exp_oe) oe_bad++;
        end
      end
      prev_sck = spi_clk_out;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] ref_ram [logic [15:0]];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : ram_init(a);
  endfunction

  // One request, starting at a negedge in an idle cycle and ending at the
  // negedge of the cycle after the response. With chaos set, req_valid stays
  // high with scrambled fields while busy, then the next request is staged.
  task automatic txn(input logic wr, input logic tgt, input logic [15:0] a, input logic [7:0] wd,
                     input bit chaos, input logic nwr, input logic ntgt,
                     input logic [15:0] na, input logic [7:0] nwd);
    int k, exp_lat, ncyc, busy_bad, rises0, txn0;
    logic rej;
    logic [7:0] exp_rd, rd0;
    rej    = wr && !tgt;
    ncyc   = 8 + 6 + (wr ? 2 : ((tgt ? RD : FD) + 2));
    exp_lat = rej ? 1 : 2 * ncyc + 1;
    rd0    = resp_rdata;
    exp_rd = (wr) ? rd0 : (tgt ? ref_rd(a) : flash_init(a));
    rises0 = sck_rises;
    txn0   = txn_cnt;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_target = tgt; req_addr = a; req_wdata = wd;
    @(posedge clock);
    k = 0; busy_bad = 0;
    while (k < 200) begin
      @(negedge clock);
      k++;
      if (req_ready) busy_bad++;
      if (resp_valid) break;
      if (chaos) begin
        req_addr = 16'($urandom); req_wdata = 8'($urandom);
        req_write = 1'($urandom); req_target = 1'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    if (chaos) begin
      req_valid = 1'b1; req_write = nwr; req_target = ntgt; req_addr = na; req_wdata = nwd;
    end else begin
      req_valid = 1'b0;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("resp_err", 32'(resp_err), 32'(rej));
    chk("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
    chk("ready_low_while_busy", 32'(busy_bad), 32'd0);
    @(negedge clock);
    chk("resp_valid_pulse", 32'(resp_valid), 32'd0);
    chk("ready_after_done", 32'(req_ready), 32'd1);
    if (rej) begin
      chk("reject_no_sck", 32'(sck_rises), 32'(rises0));
      chk("reject_no_cs", 32'(txn_cnt), 32'(txn0));
    end else begin
      chk("bus_txn_count", 32'(txn_cnt), 32'(txn0 + 1));
      chk("bus_opcode", 32'(last_cmd), wr ? 32'h38 : 32'hEB);
      chk("bus_addr", 32'(last_addr), 32'(a));
      chk("bus_target", 32'(last_tgt), 32'(tgt));
      chk("bus_sck_count", 32'(last_n), 32'(ncyc));
      if (wr) chk("bus_wdata", 32'(last_wd), 32'(wd));
    end
    if (wr && tgt) ref_ram[a] = wd;
  endtask

  initial begin
    int vbad;
    logic        wr, tgt;
    logic [15:0] a;
    logic [7:0]  wd;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_target = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_dout", 32'(spi_data_out), 32'd0);
    chk("rst_oe", 32'(spi_data_oe), 32'd0);
    chk("rst_sck", 32'(spi_clk_out), 32'd0);
    chk("rst_flash_cs", 32'(spi_flash_select), 32'd1);
    chk("rst_ram_cs", 32'(spi_ram_a_select), 32'd1);
    reset = 1'b0;
    @(negedge clock);

    // Directed scenarios
    txn(1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);   // flash read -> A5
    txn(1'b1, 1'b1, 16'h00FF, 8'h3C, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);   // RAM write
    txn(1'b0, 1'b1, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);   // RAM read back
    txn(1'b1, 1'b0, 16'h0042, 8'h99, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);   // flash write rejected
    txn(1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b0, 1'b1, 16'h00FF, 8'h0); // held request while busy
    txn(1'b0, 1'b1, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);   // staged request

    // Reset in the middle of the address phase of a flash read
    req_valid = 1'b1; req_write = 1'b0; req_target = 1'b0; req_addr = 16'h1234;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (19) @(negedge clock);
    chk("abort_cs_before", 32'(spi_flash_select), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_flash_cs", 32'(spi_flash_select), 32'd1);
    chk("abort_ram_cs", 32'(spi_ram_a_select), 32'd1);
    chk("abort_oe", 32'(spi_data_oe), 32'd0);
    chk("abort_sck", 32'(spi_clk_out), 32'd0);
    vbad = 0;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid) vbad++;
    end
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (40) begin
      @(negedge clock);
      if (resp_valid) vbad++;
    end
    chk("abort_no_resp", 32'(vbad), 32'd0);

    // Randomized traffic, addresses biased toward a small window for RAM hits
    for (int i = 0; i < 24; i++) begin
      wr  = 1'($urandom_range(0, 1));
      tgt = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      wd  = 8'($urandom);
      txn(wr, tgt, a, wd, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    end

    chk("cs_overlap", 32'(cs_both), 32'd0);
    chk("sck_without_cs", 32'(sck_idle), 32'd0);
    chk("oe_or_dummy_data", 32'(oe_bad), 32'd0);
    chk("target_stable", 32'(tgt_bad), 32'd0);
    chk("cs_high_gap_ge2", 32'(min_gap >= 2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
